// File: rtl/sm_motion_seq.sv
// rtl/sm_motion_seq.sv - stepper motion sequencer: enable/settle, accel ramp, cruise, decel ramp
//
// Ports:
//   clk         system clock (50 MHz)
//   rst         asynchronous active-low reset
//   start       one-cycle start command (ignored with stop/abort or while busy)
//   stop        one-cycle controlled stop (decelerate from the current speed)
//   abort       immediate stop to IDLE, highest priority
//   dir_cmd     direction for the next move, sampled at start
//   steps_cmd   step count for the next move, sampled at start
//   drv_step    step pulse from the pulse generator, counted as position feedback
//   drv_en_SM   driver enable
//   drv_dir     driver direction
//   pulse_en    allows the pulse generator to emit steps
//   n           current step period in clk cycles
//   busy        move in progress (SETTLE/ACCEL/RUN/DECEL)
//   done        one-cycle pulse on normal move completion
//   steps_done  steps taken in the current/last move
//   state       FSM state code for the status register
module sm_motion_seq #(
    parameter int N_W       = 17,
    parameter int CNT_W     = 24,
    parameter int N_MAX     = 8333,
    parameter int N_MIN     = 1000,
    parameter int N_STEP    = 64,
    parameter int EN_SETTLE = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic             dir_cmd,
    input  logic [CNT_W-1:0] steps_cmd,
    input  logic             drv_step,
    output logic             drv_en_SM,
    output logic             drv_dir,
    output logic             pulse_en,
    output logic [N_W-1:0]   n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_done,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_ACCEL  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DECEL  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int SET_W = (EN_SETTLE > 1) ? $clog2(EN_SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(EN_SETTLE - 1);

    localparam logic [N_W-1:0] N_MAX_W  = N_W'(N_MAX);
    localparam logic [N_W-1:0] N_MIN_W  = N_W'(N_MIN);
    localparam logic [N_W-1:0] N_STEP_W = N_W'(N_STEP);
    // One extra bit so the ramp limits can be compared without wrap.
    localparam logic [N_W:0]   FAST_LIM = (N_W + 1)'(N_MIN + N_STEP);
    localparam logic [N_W:0]   SLOW_LIM = (N_W + 1)'(N_MAX);

    logic             drv_step_q;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] ramp_cnt;
    logic [SET_W-1:0] settle_cnt;

    logic             step_edge;
    logic [CNT_W-1:0] sd_inc;
    logic [CNT_W-1:0] rc_inc;
    logic [CNT_W-1:0] rc_dec;
    logic [CNT_W-1:0] remain;
    logic [N_W:0]     n_sum;
    logic [N_W-1:0]   n_fast;
    logic [N_W-1:0]   n_slow;

    // Next-step values; transition decisions use the post-step counts.
    always_comb begin
        step_edge = drv_step & ~drv_step_q;
        sd_inc    = steps_done + CNT_W'(1);
        rc_inc    = ramp_cnt + CNT_W'(1);
        rc_dec    = (ramp_cnt == '0) ? '0 : ramp_cnt - CNT_W'(1);
        remain    = target - sd_inc;
        n_fast    = ({1'b0, n} >= FAST_LIM) ? n - N_STEP_W : N_MIN_W;
        n_sum     = {1'b0, n} + {1'b0, N_STEP_W};
        n_slow    = (n_sum >= SLOW_LIM) ? N_MAX_W : n_sum[N_W-1:0];
    end

    always_comb begin
        busy      = (state == S_SETTLE) || (state == S_ACCEL) ||
                    (state == S_RUN)    || (state == S_DECEL);
        pulse_en  = (state == S_ACCEL) || (state == S_RUN) || (state == S_DECEL);
        drv_en_SM = busy || (state == S_DONE);
        done      = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            drv_dir    <= 1'b0;
            n          <= N_MAX_W;
            steps_done <= '0;
            ramp_cnt   <= '0;
            target     <= '0;
            settle_cnt <= '0;
            drv_step_q <= 1'b0;
        end else begin
            drv_step_q <= drv_step;
            if (abort) begin
                // steps_done is deliberately left alone for readback.
                state <= S_IDLE;
                n     <= N_MAX_W;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            drv_dir    <= dir_cmd;
                            target     <= steps_cmd;
                            steps_done <= '0;
                            ramp_cnt   <= '0;
                            settle_cnt <= '0;
                            state      <= (steps_cmd == '0) ? S_DONE : S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (stop) begin
                            state <= S_IDLE;
                            n     <= N_MAX_W;
                        end else if (settle_cnt == SETTLE_LAST) begin
                            state <= S_ACCEL;
                        end else begin
                            settle_cnt <= settle_cnt + SET_W'(1);
                        end
                    end
                    S_ACCEL: begin
                        if (step_edge) begin
                            steps_done <= sd_inc;
                            ramp_cnt   <= rc_inc;
                            n          <= n_fast;
                            if (sd_inc == target)                 state <= S_DONE;
                            else if (stop || remain <= rc_inc)   state <= S_DECEL;
                            else if (n_fast == N_MIN_W)          state <= S_RUN;
                        end else if (stop) begin
                            state <= S_DECEL;
                        end
                    end
                    S_RUN: begin
                        if (step_edge) begin
                            steps_done <= sd_inc;
                            if (sd_inc == target)                 state <= S_DONE;
                            else if (stop || remain <= ramp_cnt) state <= S_DECEL;
                        end else if (stop) begin
                            state <= S_DECEL;
                        end
                    end
                    S_DECEL: begin
                        if (step_edge) begin
                            steps_done <= sd_inc;
                            ramp_cnt   <= rc_dec;
                            n          <= n_slow;
                            if ((sd_inc == target) || (rc_dec == '0)) state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        n     <= N_MAX_W;
                    end
                    default: begin
                        state <= S_IDLE;
                        n     <= N_MAX_W;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sm_motion_seq.sv
// tb/tb_sm_motion_seq.sv - self-checking bench for sm_motion_seq
module tb_sm_motion_seq;

    localparam int N_W    = 17;
    localparam int CNT_W  = 24;
    localparam int NMAX   = 100;
    localparam int NMIN   = 40;
    localparam int NSTEP  = 20;
    localparam int SETTLE = 10;

    localparam int P_IDLE = 0, P_SETTLE = 1, P_ACCEL = 2, P_RUN = 3, P_DECEL = 4, P_DONE = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             abort = 1'b0;
    logic             dir_cmd = 1'b0;
    logic [CNT_W-1:0] steps_cmd = '0;
    logic             drv_step = 1'b0;
    logic             drv_en_SM;
    logic             drv_dir;
    logic             pulse_en;
    logic [N_W-1:0]   n;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps_done;
    logic [2:0]       state;

    int total = 0;
    int bad   = 0;

    sm_motion_seq #(
        .N_W(N_W), .CNT_W(CNT_W), .N_MAX(NMAX), .N_MIN(NMIN),
        .N_STEP(NSTEP), .EN_SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .abort(abort),
        .dir_cmd(dir_cmd), .steps_cmd(steps_cmd), .drv_step(drv_step),
        .drv_en_SM(drv_en_SM), .drv_dir(drv_dir), .pulse_en(pulse_en), .n(n),
        .busy(busy), .done(done), .steps_done(steps_done), .state(state)
    );

    always #5 clk = ~clk;

    // Pulse generator: one-cycle drv_step every n cycles while pulse_en is high.
    int pg_cnt = 0;
    always @(negedge clk) begin
        if (!pulse_en) begin
            pg_cnt   = 0;
            drv_step = 1'b0;
        end else if (pg_cnt >= int'(n) - 1) begin
            drv_step = 1'b1;
            pg_cnt   = 0;
        end else begin
            drv_step = 1'b0;
            pg_cnt++;
        end
    end

    // Behavioural model of the move profile.
    int m_phase = P_IDLE, m_n = NMAX, m_target = 0, m_sd = 0, m_ramp = 0, m_settle = 0;
    bit m_dir = 0, m_prev = 0;

    task automatic model_reset();
        m_phase = P_IDLE; m_n = NMAX; m_target = 0; m_sd = 0; m_ramp = 0;
        m_settle = 0; m_dir = 0; m_prev = 0;
    endtask

    task automatic model_step();
        bit edge_seen;
        edge_seen = drv_step && !m_prev;
        m_prev    = drv_step;
        if (abort) begin
            m_phase = P_IDLE;
            m_n     = NMAX;
            return;
        end
        case (m_phase)
            P_IDLE: if (start && !stop) begin
                m_dir = dir_cmd; m_target = int'(steps_cmd); m_sd = 0; m_ramp = 0;
                if (m_target == 0) m_phase = P_DONE;
                else begin m_phase = P_SETTLE; m_settle = SETTLE; end
            end
            P_SETTLE: begin
                if (stop) begin m_phase = P_IDLE; m_n = NMAX; end
                else begin
                    m_settle--;
                    if (m_settle == 0) m_phase = P_ACCEL;
                end
            end
            P_ACCEL, P_RUN, P_DECEL: begin
                if (edge_seen) begin
                    m_sd++;
                    if (m_phase == P_ACCEL) begin
                        m_ramp++;
                        m_n = (m_n - NSTEP < NMIN) ? NMIN : m_n - NSTEP;
                    end else if (m_phase == P_DECEL) begin
                        m_ramp = (m_ramp > 0) ? m_ramp - 1 : 0;
                        m_n = (m_n + NSTEP > NMAX) ? NMAX : m_n + NSTEP;
                    end
                    if (m_sd == m_target) m_phase = P_DONE;
                    else if (m_phase == P_DECEL) begin
                        if (m_ramp == 0) m_phase = P_DONE;
                    end
                    else if (stop || (m_target - m_sd) <= m_ramp) m_phase = P_DECEL;
                    else if (m_phase == P_ACCEL && m_n == NMIN) m_phase = P_RUN;
                end else if (stop && m_phase != P_DECEL) begin
                    m_phase = P_DECEL;
                end
            end
            P_DONE: begin m_phase = P_IDLE; m_n = NMAX; end
            default: m_phase = P_IDLE;
        endcase
    endtask

    always @(posedge clk) begin
        if (!rst) model_reset();
        else model_step();
    end

    // Per-cycle comparison plus DUT-side event logs.
    bit cmp_en = 0;
    int n_log[$];
    int done_cnt = 0, pe_cycles = 0, settle_cycles = 0, run_step = -1, decel_step = -1;
    int prev_sd = 0, prev_state = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            bit e_busy, e_pe, e_en, e_done;
            e_busy = (m_phase >= P_SETTLE) && (m_phase <= P_DECEL);
            e_pe   = (m_phase >= P_ACCEL) && (m_phase <= P_DECEL);
            e_en   = e_busy || (m_phase == P_DONE);
            e_done = (m_phase == P_DONE);
            total++;
            if (int'(state) != m_phase || drv_en_SM !== e_en || pulse_en !== e_pe ||
                drv_dir !== m_dir || int'(n) != m_n || busy !== e_busy ||
                done !== e_done || int'(steps_done) != m_sd) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got state=%0d en=%0b pe=%0b dir=%0b n=%0d busy=%0b done=%0b sd=%0d want state=%0d en=%0b pe=%0b dir=%0b n=%0d busy=%0b done=%0b sd=%0d",
                         $time, state, drv_en_SM, pulse_en, drv_dir, n, busy, done, steps_done,
                         m_phase, e_en, e_pe, m_dir, m_n, e_busy, e_done, m_sd);
            end
            if (done) done_cnt++;
            if (pulse_en) pe_cycles++;
            if (state == 3'd1) settle_cycles++;
            if (int'(steps_done) == prev_sd + 1) n_log.push_back(int'(n));
            if (state == 3'd3 && prev_state != 3) run_step = int'(steps_done);
            if (state == 3'd4 && prev_state != 4) decel_step = int'(steps_done);
            prev_sd    = int'(steps_done);
            prev_state = int'(state);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_logs();
        n_log.delete();
        done_cnt = 0; pe_cycles = 0; settle_cycles = 0; run_step = -1; decel_step = -1;
    endtask

    task automatic do_start(input int cnt, input bit dir);
        nclk();
        steps_cmd = CNT_W'(cnt);
        dir_cmd   = dir;
        start     = 1'b1;
        nclk();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (state != 3'd0 && k < budget) begin nclk(); k++; end
        chk({name, "_idle"}, state, 0);
    endtask

    task automatic wait_steps(input string name, input int v, input int budget);
        int k = 0;
        while (int'(steps_done) != v && k < budget) begin nclk(); k++; end
        chk({name, "_reach"}, steps_done, v);
    endtask

    task automatic chk_nlog(input string name, input int exp[$]);
        chk({name, "_nlen"}, n_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < n_log.size(); i++)
            chk($sformatf("%s_n%0d", name, i + 1), n_log[i], exp[i]);
    endtask

    int e1[$] = '{80, 60, 40, 40, 40, 40, 40, 60, 80, 100};
    int e2[$] = '{80, 60, 80, 100};
    int e4[$] = '{80, 60, 40, 40, 40, 60, 80, 100};
    int e6[$] = '{80, 100};

    initial begin
        repeat (3) nclk();
        cmp_en = 1;
        chk("rst_state", state, 0);
        chk("rst_n", n, NMAX);
        chk("rst_en", drv_en_SM, 0);
        chk("rst_pe", pulse_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sd", steps_done, 0);
        rst = 1'b1;
        nclk();

        // 1: full profile
        clr_logs();
        do_start(10, 1);
        chk("t1_en", drv_en_SM, 1);
        chk("t1_dir", drv_dir, 1);
        chk("t1_state", state, 1);
        wait_idle("t1", 3000);
        chk("t1_settle", settle_cycles, SETTLE);
        chk_nlog("t1", e1);
        chk("t1_run_at", run_step, 3);
        chk("t1_decel_at", decel_step, 7);
        chk("t1_done", done_cnt, 1);
        chk("t1_sd", steps_done, 10);

        // 2: short move, no cruise
        clr_logs();
        do_start(4, 0);
        wait_idle("t2", 2000);
        chk_nlog("t2", e2);
        chk("t2_run_at", run_step, -1);
        chk("t2_decel_at", decel_step, 2);
        chk("t2_done", done_cnt, 1);
        chk("t2_sd", steps_done, 4);
        chk("t2_dir", drv_dir, 0);

        // 3: zero-length move
        clr_logs();
        do_start(0, 0);
        chk("t3_state", state, 5);
        chk("t3_donepulse", done, 1);
        nclk();
        chk("t3_state2", state, 0);
        chk("t3_done2", done, 0);
        chk("t3_pe", pe_cycles, 0);
        chk("t3_done", done_cnt, 1);
        chk("t3_sd", steps_done, 0);

        // 4: controlled stop in RUN
        clr_logs();
        do_start(100, 1);
        wait_steps("t4", 5, 3000);
        chk("t4_state5", state, 3);
        chk("t4_n5", n, 40);
        stop = 1'b1;
        nclk();
        stop = 1'b0;
        chk("t4_decel", state, 4);
        wait_idle("t4", 3000);
        chk_nlog("t4", e4);
        chk("t4_decel_at", decel_step, 5);
        chk("t4_done", done_cnt, 1);
        chk("t4_sd", steps_done, 8);

        // 5: start while busy ignored, then abort in RUN
        clr_logs();
        do_start(20, 0);
        steps_cmd = CNT_W'(5);
        dir_cmd   = 1'b1;
        start     = 1'b1;
        nclk();
        start     = 1'b0;
        wait_steps("t5", 6, 3000);
        chk("t5_run", state, 3);
        abort = 1'b1;
        nclk();
        abort = 1'b0;
        chk("t5_en", drv_en_SM, 0);
        chk("t5_pe", pulse_en, 0);
        chk("t5_n", n, NMAX);
        chk("t5_state", state, 0);
        chk("t5_sd", steps_done, 6);
        chk("t5_dir", drv_dir, 0);
        repeat (3) nclk();
        chk("t5_done", done_cnt, 0);
        chk("t5_idle", state, 0);

        // 6: async reset mid-ACCEL, then a normal move
        do_start(50, 1);
        wait_steps("t6", 1, 2000);
        chk("t6_accel", state, 2);
        #1 rst = 1'b0;
        #1;
        chk("t6_state", state, 0);
        chk("t6_en", drv_en_SM, 0);
        chk("t6_pe", pulse_en, 0);
        chk("t6_n", n, NMAX);
        chk("t6_dir", drv_dir, 0);
        chk("t6_sd", steps_done, 0);
        chk("t6_busy", busy, 0);
        repeat (2) nclk();
        rst = 1'b1;
        nclk();
        clr_logs();
        do_start(2, 0);
        wait_idle("t6b", 2000);
        chk_nlog("t6b", e6);
        chk("t6b_decel_at", decel_step, 1);
        chk("t6b_done", done_cnt, 1);
        chk("t6b_sd", steps_done, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
